// File: rtl/l2_cache_control_nway_pkg.sv
// rtl/l2_cache_control_nway_pkg.sv - shared types and defaults for the n-way L2 cache controller
package l2_cache_control_nway_pkg;

    localparam int L2_WAYS = 4;
    localparam int L2_SETS = 8;

    typedef enum logic [1:0] {
        L2_IDLE,
        L2_COMPARE,
        L2_WRITE_BACK,
        L2_ALLOCATE
    } l2_state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/l2_cache_control_nway_if.sv
// rtl/l2_cache_control_nway_if.sv - arbiter, memory and tag/data array signals of the L2 controller
interface l2_cache_control_nway_if
    import l2_cache_control_nway_pkg::*;
#(
    parameter int WAYS = L2_WAYS,
    parameter int SETS = L2_SETS
) ();
    localparam int SET_BITS = $clog2(SETS);
    localparam int WAY_BITS = $clog2(WAYS);

    logic                l2arb_mem_read;
    logic                l2arb_mem_write;
    logic                l2arb_mem_resp;
    logic                pmem_read;
    logic                pmem_write;
    logic                pmem_resp;
    logic [SET_BITS-1:0] set_idx;
    logic [WAYS-1:0]     hit_vec;
    logic [WAYS-1:0]     valid_vec;
    logic [WAYS-1:0]     dirty_vec;
    logic [WAYS-1:0]     wr_valid;
    logic [WAYS-1:0]     wr_tag;
    logic [WAYS-1:0]     wr_data;
    logic [WAYS-1:0]     wr_dirty;
    logic                dirty_in;
    logic                din_sel;
    logic                addrmux_sel;
    logic [WAY_BITS-1:0] dout_sel;

    // master: arbiter, memory and arrays around the controller
    modport master (
        output l2arb_mem_read, l2arb_mem_write, pmem_resp, set_idx, hit_vec, valid_vec, dirty_vec,
        input  l2arb_mem_resp, pmem_read, pmem_write, wr_valid, wr_tag, wr_data, wr_dirty,
        input  dirty_in, din_sel, addrmux_sel, dout_sel
    );

    modport slave (
        input  l2arb_mem_read, l2arb_mem_write, pmem_resp, set_idx, hit_vec, valid_vec, dirty_vec,
        output l2arb_mem_resp, pmem_read, pmem_write, wr_valid, wr_tag, wr_data, wr_dirty,
        output dirty_in, din_sel, addrmux_sel, dout_sel
    );

endinterface

// File: rtl/l2_cache_control_nway_plru.sv
// rtl/l2_cache_control_nway_plru.sv - per-set tree pseudo-LRU state with victim read and MRU update
module l2_plru
    import l2_cache_control_nway_pkg::*;
#(
    parameter int WAYS = L2_WAYS,
    parameter int SETS = L2_SETS,
    localparam int SET_BITS = $clog2(SETS),
    localparam int WAY_BITS = $clog2(WAYS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SET_BITS-1:0] set_idx,
    output logic [WAY_BITS-1:0] victim,
    input  logic                upd_en,
    input  logic [WAY_BITS-1:0] upd_way
);
    // Node n has children 2n+1 (bit 0) and 2n+2 (bit 1); each bit points toward the LRU half.
    logic [WAYS-2:0] tree [SETS];
    logic [WAYS-2:0] cur;
    logic [WAYS-2:0] upd;

    always_comb begin
        int node;
        cur    = tree[set_idx];
        victim = '0;
        node   = 0;
        for (int l = 0; l < WAY_BITS; l++) begin
            victim[WAY_BITS-1-l] = cur[node];
            node = 2 * node + 1 + int'(cur[node]);
        end
        upd  = cur;
        node = 0;
        for (int l = 0; l < WAY_BITS; l++) begin
            upd[node] = ~upd_way[WAY_BITS-1-l];
            node = 2 * node + 1 + int'(upd_way[WAY_BITS-1-l]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) tree[s] <= '0;
        end else if (upd_en) begin
            tree[set_idx] <= upd;
        end
    end

endmodule

// File: rtl/l2_cache_control_nway.sv
// rtl/l2_cache_control_nway.sv - n-way write-back L2 controller FSM; L2_PERF_CNT_EN adds hit/miss/writeback counters
module l2_cache_control_nway
    import l2_cache_control_nway_pkg::*;
#(
    parameter int WAYS = L2_WAYS,
    parameter int SETS = L2_SETS
) (
    input  logic                    clk,
    input  logic                    rst_n,
    l2_cache_control_nway_if.slave  bus
`ifdef L2_PERF_CNT_EN
    ,
    output logic [31:0]             hit_count,
    output logic [31:0]             miss_count,
    output logic [31:0]             wb_count
`endif
);
    localparam int WAY_BITS = $clog2(WAYS);

    l2_state_t           state, state_n;
    logic [WAY_BITS-1:0] victim_q, victim_n;
    logic [WAY_BITS-1:0] hit_way, invalid_way, plru_way;
    logic [WAYS-1:0]     hit_oh, victim_oh;
    logic                req, hit, is_write, any_invalid, plru_upd;

    assign req       = bus.l2arb_mem_read | bus.l2arb_mem_write;
    assign is_write  = bus.l2arb_mem_write & ~bus.l2arb_mem_read;
    assign hit       = |bus.hit_vec;
    assign hit_oh    = WAYS'(1) << hit_way;
    assign victim_oh = WAYS'(1) << victim_q;

    // Descending scans so the lowest matching index wins.
    always_comb begin
        hit_way     = '0;
        invalid_way = '0;
        any_invalid = 1'b0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (bus.hit_vec[i]) hit_way = WAY_BITS'(i);
            if (!bus.valid_vec[i]) begin
                invalid_way = WAY_BITS'(i);
                any_invalid = 1'b1;
            end
        end
    end

    l2_plru #(.WAYS(WAYS), .SETS(SETS)) u_plru (
        .clk     (clk),
        .rst_n   (rst_n),
        .set_idx (bus.set_idx),
        .victim  (plru_way),
        .upd_en  (plru_upd),
        .upd_way (hit_way)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= L2_IDLE;
            victim_q <= '0;
        end else begin
            state    <= state_n;
            victim_q <= victim_n;
        end
    end

    always_comb begin
        state_n            = state;
        victim_n           = victim_q;
        plru_upd           = 1'b0;
        bus.l2arb_mem_resp = 1'b0;
        bus.pmem_read      = 1'b0;
        bus.pmem_write     = 1'b0;
        bus.wr_valid       = '0;
        bus.wr_tag         = '0;
        bus.wr_data        = '0;
        bus.wr_dirty       = '0;
        bus.dirty_in       = 1'b0;
        bus.din_sel        = 1'b0;
        bus.addrmux_sel    = 1'b0;
        bus.dout_sel       = hit_way;
        case (state)
            L2_IDLE: begin
                if (req) state_n = L2_COMPARE;
            end
            L2_COMPARE: begin
                if (!req) begin
                    state_n = L2_IDLE;
                end else if (hit) begin
                    bus.l2arb_mem_resp = 1'b1;
                    plru_upd           = 1'b1;
                    if (is_write) begin
                        bus.din_sel  = 1'b1;
                        bus.dirty_in = 1'b1;
                        bus.wr_data  = hit_oh;
                        bus.wr_dirty = hit_oh;
                    end
                    state_n = L2_IDLE;
                end else begin
                    victim_n = any_invalid ? invalid_way : plru_way;
                    state_n  = (bus.valid_vec[victim_n] && bus.dirty_vec[victim_n])
                               ? L2_WRITE_BACK : L2_ALLOCATE;
                end
            end
            L2_WRITE_BACK: begin
                bus.pmem_write  = 1'b1;
                bus.addrmux_sel = 1'b1;
                bus.dout_sel    = victim_q;
                if (bus.pmem_resp) state_n = L2_ALLOCATE;
            end
            L2_ALLOCATE: begin
                bus.pmem_read = 1'b1;
                bus.wr_valid  = victim_oh;
                bus.wr_tag    = victim_oh;
                bus.wr_data   = victim_oh;
                bus.wr_dirty  = victim_oh;
                if (bus.pmem_resp) state_n = L2_COMPARE;
            end
            default: state_n = L2_IDLE;
        endcase
    end

`ifdef L2_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
            wb_count   <= '0;
        end else begin
            if (state == L2_COMPARE && req && hit)  hit_count  <= sat_inc(hit_count);
            if (state == L2_COMPARE && req && !hit) miss_count <= sat_inc(miss_count);
            if (state == L2_WRITE_BACK && bus.pmem_resp) wb_count <= sat_inc(wb_count);
        end
    end
`endif

endmodule

// File: tb/tb_l2_cache_control_nway.sv
// tb/tb_l2_cache_control_nway.sv - directed self-checking bench for l2_cache_control_nway
module tb_l2_cache_control_nway;
    import l2_cache_control_nway_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    l2_cache_control_nway_if #(.WAYS(4), .SETS(8)) bus ();

`ifdef L2_PERF_CNT_EN
    logic [31:0] hit_count, miss_count, wb_count;
    l2_cache_control_nway #(.WAYS(4), .SETS(8)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
    );
`else
    l2_cache_control_nway #(.WAYS(4), .SETS(8)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
`endif

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic rd, input logic wr, input logic [2:0] s,
                       input logic [3:0] h, input logic [3:0] v, input logic [3:0] d);
        bus.l2arb_mem_read  = rd;
        bus.l2arb_mem_write = wr;
        bus.set_idx         = s;
        bus.hit_vec         = h;
        bus.valid_vec       = v;
        bus.dirty_vec       = d;
    endtask

    task automatic idle;
        req(1'b0, 1'b0, 3'd0, 4'b0, 4'b0, 4'b0);
        bus.pmem_resp = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        tick; tick; #1;
        chk("rst_pmem_read",  32'(bus.pmem_read), 32'd0);
        chk("rst_pmem_write", 32'(bus.pmem_write), 32'd0);
        chk("rst_resp",       32'(bus.l2arb_mem_resp), 32'd0);
        chk("rst_wr_valid",   32'(bus.wr_valid), 32'd0);
        chk("rst_addrmux",    32'(bus.addrmux_sel), 32'd0);
        chk("rst_dout_sel",   32'(bus.dout_sel), 32'd0);
        tick; rst_n = 1'b1;

        // read hit way 2, set 3
        tick; req(1, 0, 3, 4'b0100, 4'b1111, 4'b0000); #1;
        chk("a_idle_resp", 32'(bus.l2arb_mem_resp), 32'd0);
        tick; #1;
        chk("a_resp",     32'(bus.l2arb_mem_resp), 32'd1);
        chk("a_dout_sel", 32'(bus.dout_sel), 32'd2);
        chk("a_wr_data",  32'(bus.wr_data), 32'd0);
        tick; idle(); #1;
        chk("a_resp_pulse", 32'(bus.l2arb_mem_resp), 32'd0);

        // read hit way 0, set 3 (PLRU for set 3 now points to way 3)
        tick; req(1, 0, 3, 4'b0001, 4'b1111, 4'b0000);
        tick; #1;
        chk("b_resp",     32'(bus.l2arb_mem_resp), 32'd1);
        chk("b_dout_sel", 32'(bus.dout_sel), 32'd0);
        tick; idle();

        // write miss set 3, all valid and dirty: PLRU victim 3 written back then filled
        tick; req(0, 1, 3, 4'b0000, 4'b1111, 4'b1111);
        tick; #1;
        chk("c_cmp_resp",   32'(bus.l2arb_mem_resp), 32'd0);
        chk("c_cmp_pwrite", 32'(bus.pmem_write), 32'd0);
        tick; #1;
        chk("c_wb_pwrite",  32'(bus.pmem_write), 32'd1);
        chk("c_wb_addrmux", 32'(bus.addrmux_sel), 32'd1);
        chk("c_wb_dout",    32'(bus.dout_sel), 32'd3);
        chk("c_wb_pread",   32'(bus.pmem_read), 32'd0);
        tick; #1;
        chk("c_wb_hold",    32'(bus.pmem_write), 32'd1);
        bus.pmem_resp = 1'b1;
        tick; bus.pmem_resp = 1'b0; #1;
        chk("c_al_pread",   32'(bus.pmem_read), 32'd1);
        chk("c_al_pwrite",  32'(bus.pmem_write), 32'd0);
        chk("c_al_wr_valid", 32'(bus.wr_valid), 32'h8);
        chk("c_al_wr_tag",  32'(bus.wr_tag), 32'h8);
        chk("c_al_din_sel", 32'(bus.din_sel), 32'd0);
        bus.pmem_resp = 1'b1;
        tick; bus.pmem_resp = 1'b0; bus.hit_vec = 4'b1000; #1;
        chk("c_hit_resp",     32'(bus.l2arb_mem_resp), 32'd1);
        chk("c_hit_wr_data",  32'(bus.wr_data), 32'h8);
        chk("c_hit_wr_dirty", 32'(bus.wr_dirty), 32'h8);
        chk("c_hit_dirty_in", 32'(bus.dirty_in), 32'd1);
        chk("c_hit_din_sel",  32'(bus.din_sel), 32'd1);
        chk("c_hit_pread",    32'(bus.pmem_read), 32'd0);
        tick; idle();

        // write hit way 1
        tick; req(0, 1, 5, 4'b0010, 4'b1111, 4'b0000);
        tick; #1;
        chk("d_wr_data",  32'(bus.wr_data), 32'h2);
        chk("d_wr_dirty", 32'(bus.wr_dirty), 32'h2);
        chk("d_dirty_in", 32'(bus.dirty_in), 32'd1);
        chk("d_resp",     32'(bus.l2arb_mem_resp), 32'd1);
        tick; idle();

        // read miss with way 2 invalid: victim 2, straight to ALLOCATE
        tick; req(1, 0, 2, 4'b0000, 4'b1011, 4'b1011);
        tick; #1;
        chk("e_cmp_resp", 32'(bus.l2arb_mem_resp), 32'd0);
        tick; #1;
        chk("e_pwrite",   32'(bus.pmem_write), 32'd0);
        chk("e_pread",    32'(bus.pmem_read), 32'd1);
        chk("e_wr_valid", 32'(bus.wr_valid), 32'h4);
        bus.pmem_resp = 1'b1;
        tick; bus.pmem_resp = 1'b0; bus.hit_vec = 4'b0100; #1;
        chk("e_hit_resp",    32'(bus.l2arb_mem_resp), 32'd1);
        chk("e_hit_wr_data", 32'(bus.wr_data), 32'd0);
        tick; idle();

        // read and write together behave as a read
        tick; req(1, 1, 6, 4'b0010, 4'b1111, 4'b0000);
        tick; #1;
        chk("f_resp",     32'(bus.l2arb_mem_resp), 32'd1);
        chk("f_wr_data",  32'(bus.wr_data), 32'd0);
        chk("f_dirty_in", 32'(bus.dirty_in), 32'd0);
        tick; idle();

        // multiple hit bits: lowest way
        tick; req(1, 0, 6, 4'b0110, 4'b1111, 4'b0000);
        tick; #1;
        chk("g_dout_sel", 32'(bus.dout_sel), 32'd1);
        chk("g_resp",     32'(bus.l2arb_mem_resp), 32'd1);
        tick; idle();

        // request dropped in COMPARE
        tick; req(1, 0, 0, 4'b0000, 4'b0000, 4'b0000);
        tick; idle(); #1;
        chk("h_resp",     32'(bus.l2arb_mem_resp), 32'd0);
        chk("h_wr_valid", 32'(bus.wr_valid), 32'd0);
        tick; #1;
        chk("h_pread",  32'(bus.pmem_read), 32'd0);
        chk("h_pwrite", 32'(bus.pmem_write), 32'd0);

        // asynchronous reset in ALLOCATE
        tick; req(1, 0, 1, 4'b0000, 4'b0000, 4'b0000);
        tick; tick; #1;
        chk("i_pread", 32'(bus.pmem_read), 32'd1);
        rst_n = 1'b0; #1;
        chk("i_rst_pread",    32'(bus.pmem_read), 32'd0);
        chk("i_rst_wr_valid", 32'(bus.wr_valid), 32'd0);
        idle();
        tick; rst_n = 1'b1;
        tick; #1;
        chk("i_idle_pread", 32'(bus.pmem_read), 32'd0);
        chk("i_idle_resp",  32'(bus.l2arb_mem_resp), 32'd0);

        // PLRU cleared by reset: set 3 all-valid clean miss picks way 0
        tick; req(1, 0, 3, 4'b0000, 4'b1111, 4'b0000);
        tick; tick; #1;
        chk("j_pwrite",   32'(bus.pmem_write), 32'd0);
        chk("j_wr_valid", 32'(bus.wr_valid), 32'h1);
        bus.pmem_resp = 1'b1;
        tick; bus.pmem_resp = 1'b0; bus.hit_vec = 4'b0001; #1;
        chk("j_resp", 32'(bus.l2arb_mem_resp), 32'd1);
        tick; idle();

        // set 4 all valid and dirty: writeback of way 0, fill, hit
        tick; req(1, 0, 4, 4'b0000, 4'b1111, 4'b1111);
        tick; tick; #1;
        chk("k_pwrite",   32'(bus.pmem_write), 32'd1);
        chk("k_dout_sel", 32'(bus.dout_sel), 32'd0);
        bus.pmem_resp = 1'b1;
        tick; bus.pmem_resp = 1'b0; #1;
        chk("k_wr_valid", 32'(bus.wr_valid), 32'h1);
        bus.pmem_resp = 1'b1;
        tick; bus.pmem_resp = 1'b0; bus.hit_vec = 4'b0001; #1;
        chk("k_resp", 32'(bus.l2arb_mem_resp), 32'd1);
        tick; idle();

        tick; req(1, 0, 4, 4'b0001, 4'b1111, 4'b0000);
        tick; #1;
        chk("l_resp", 32'(bus.l2arb_mem_resp), 32'd1);
        tick; idle();
        tick; #1;

`ifdef L2_PERF_CNT_EN
        chk("perf_hits",   hit_count, 32'd3);
        chk("perf_misses", miss_count, 32'd2);
        chk("perf_wbs",    wb_count, 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
